// File: rtl/loader_pkg.sv
// Shared types and constants for the external program/data loader.
// Holds the FSM encoding, the memory read latency and the word-to-byte address helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_I   = 3'd1,
    ST_LOAD_D   = 3'd2,
    ST_VERIFY_I = 3'd3,
    ST_VERIFY_D = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAIL     = 3'd6
  } loader_state_e;

  localparam int RD_LAT      = 1;
  localparam int BYTE_STRIDE = 4;
  localparam int CNT_W       = 11;

  function automatic logic [31:0] byte_addr(input logic [CNT_W-1:0] idx);
    return 32'(idx) * 32'(BYTE_STRIDE);
  endfunction

endpackage

// File: rtl/readback_checker.sv
// Delays the read strobes by the memory latency, accumulates the returned words
// and compares the read checksums against the write checksums.
module readback_checker
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        ren_i_i,
  input  logic        ren_d_i,
  input  logic [31:0] rdata_i_i,
  input  logic [31:0] rdata_d_i,
  input  logic [31:0] wsum_i_i,
  input  logic [31:0] wsum_d_i,
  output logic        match_o
);

  logic [RD_LAT-1:0] pipe_i_q, pipe_d_q;
  logic [31:0]       rsum_i_q, rsum_d_q;
  logic [31:0]       rsum_i_d, rsum_d_d;

  // The compare looks at the next-cycle sums so the word returning this cycle
  // is already included when the FSM decides on its final transition.
  always_comb begin
    rsum_i_d = rsum_i_q + (pipe_i_q[RD_LAT-1] ? rdata_i_i : 32'd0);
    rsum_d_d = rsum_d_q + (pipe_d_q[RD_LAT-1] ? rdata_d_i : 32'd0);
    match_o  = (rsum_i_d == wsum_i_i) && (rsum_d_d == wsum_d_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_i_q <= '0;
      pipe_d_q <= '0;
      rsum_i_q <= '0;
      rsum_d_q <= '0;
    end else begin
      pipe_i_q <= RD_LAT'({pipe_i_q, ren_i_i});
      pipe_d_q <= RD_LAT'({pipe_d_q, ren_d_i});
      if (clear_i) begin
        rsum_i_q <= '0;
        rsum_d_q <= '0;
      end else begin
        rsum_i_q <= rsum_i_d;
        rsum_d_q <= rsum_d_d;
      end
    end
  end

endmodule

// File: rtl/ext_loader.sv
// Streams host words into instruction then data memory, reads both back to
// confirm their checksums, and enables the CPU only when both match.
module ext_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          start,
  input  logic [9:0]    imem_count,
  input  logic [10:0]   dmem_count,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic [31:0]   addr_ext,
  output logic          wen_ext,
  output logic          ren_ext,
  output logic [31:0]   wdata_ext,
  input  logic [31:0]   rdata_ext,
  output logic [31:0]   addr_ext_2,
  output logic          wen_ext_2,
  output logic          ren_ext_2,
  output logic [31:0]   wdata_ext_2,
  input  logic [31:0]   rdata_ext_2,
  output logic          cpu_enable,
  output logic          busy,
  output logic          done,
  output logic          error,
  output loader_state_e dbg_state
);

  // Stream handshake: a word transfers on a rising edge where s_valid && s_ready.
  // s_ready is a pure decode of the state; s_data must be stable while s_valid=1.

  localparam logic [31:0] IMAX = 32'(IMEM_WORDS);
  localparam logic [31:0] DMAX = 32'(DMEM_WORDS);

  loader_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       icnt_q;
  logic [10:0]      dcnt_q;
  logic [31:0]      wsum_i_q, wsum_d_q;

  logic             in_li, in_ld, in_vi, in_vd;
  logic [CNT_W-1:0] cur_cnt;
  logic             load_last, vfy_last, rd_issue, start_ok, too_big, match;

  always_comb begin
    in_li     = (state_q == ST_LOAD_I);
    in_ld     = (state_q == ST_LOAD_D);
    in_vi     = (state_q == ST_VERIFY_I);
    in_vd     = (state_q == ST_VERIFY_D);
    cur_cnt   = (in_li || in_vi) ? {1'b0, icnt_q} : dcnt_q;
    load_last = (cnt_q == cur_cnt - 11'd1);
    rd_issue  = (in_vi || in_vd) && (cnt_q < cur_cnt);
    // Keep counting past the last read until its data has been summed.
    vfy_last  = (cur_cnt == '0) || (cnt_q == cur_cnt + CNT_W'(RD_LAT - 1));
    start_ok  = start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_FAIL);
    too_big   = ({22'd0, imem_count} > IMAX) || ({21'd0, dmem_count} > DMAX);
  end

  assign s_ready     = in_li || in_ld;
  assign wen_ext     = in_li && s_valid;
  assign ren_ext     = in_vi && rd_issue;
  assign addr_ext    = (in_li || in_vi) ? byte_addr(cnt_q) : 32'd0;
  assign wdata_ext   = in_li ? s_data : 32'd0;
  assign wen_ext_2   = in_ld && s_valid;
  assign ren_ext_2   = in_vd && rd_issue;
  assign addr_ext_2  = (in_ld || in_vd) ? byte_addr(cnt_q) : 32'd0;
  assign wdata_ext_2 = in_ld ? s_data : 32'd0;
  assign cpu_enable  = (state_q == ST_RUN);
  assign done        = (state_q == ST_RUN);
  assign error       = (state_q == ST_FAIL);
  assign busy        = in_li || in_ld || in_vi || in_vd;
  assign dbg_state   = state_q;

  readback_checker u_chk (
    .clk       (clk),
    .rst_n     (arst_n),
    .clear_i   (start_ok),
    .ren_i_i   (ren_ext),
    .ren_d_i   (ren_ext_2),
    .rdata_i_i (rdata_ext),
    .rdata_d_i (rdata_ext_2),
    .wsum_i_i  (wsum_i_q),
    .wsum_d_i  (wsum_d_q),
    .match_o   (match)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
      wsum_i_q <= '0;
      wsum_d_q <= '0;
    end else if (start_ok) begin
      icnt_q   <= imem_count;
      dcnt_q   <= dmem_count;
      cnt_q    <= '0;
      wsum_i_q <= '0;
      wsum_d_q <= '0;
      if (too_big)                state_q <= ST_FAIL;
      else if (imem_count != '0)  state_q <= ST_LOAD_I;
      else if (dmem_count != '0)  state_q <= ST_LOAD_D;
      else                        state_q <= ST_VERIFY_I;
    end else begin
      case (state_q)
        ST_LOAD_I: if (s_valid) begin
          wsum_i_q <= wsum_i_q + s_data;
          if (load_last) begin
            cnt_q   <= '0;
            state_q <= (dcnt_q != '0) ? ST_LOAD_D : ST_VERIFY_I;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        ST_LOAD_D: if (s_valid) begin
          wsum_d_q <= wsum_d_q + s_data;
          if (load_last) begin
            cnt_q   <= '0;
            state_q <= ST_VERIFY_I;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        ST_VERIFY_I: begin
          if (vfy_last) begin
            cnt_q <= '0;
            if (dcnt_q != '0) state_q <= ST_VERIFY_D;
            else              state_q <= match ? ST_RUN : ST_FAIL;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        ST_VERIFY_D: begin
          if (vfy_last) begin
            cnt_q   <= '0;
            state_q <= match ? ST_RUN : ST_FAIL;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_loader.sv
// Directed bench for ext_loader with a one-cycle-latency memory model per port
// and a write scoreboard fed from the expected-write queue.
module tb_ext_loader;
  import loader_pkg::*;

  logic          clk, arst_n, start, s_valid, s_ready;
  logic [9:0]    imem_count;
  logic [10:0]   dmem_count;
  logic [31:0]   s_data;
  logic [31:0]   addr_ext, wdata_ext, rdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic          wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic          cpu_enable, busy, done, error;
  loader_state_e dbg_state;

  int tests = 0;
  int fails = 0;
  int wcount = 0;
  logic corrupt_d1 = 1'b0;
  logic [64:0] exp_q[$];
  logic [31:0] imem [16];
  logic [31:0] dmem [16];

  ext_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_count(imem_count), .dmem_count(dmem_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // Clock and reset-time defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: read data appears one cycle after ren
  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
    rdata_ext   = '0;
    rdata_ext_2 = '0;
  end

  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[5:2]] <= wdata_ext;
    if (ren_ext)   rdata_ext <= imem[addr_ext[5:2]];
    if (wen_ext_2) dmem[addr_ext_2[5:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= (corrupt_d1 && addr_ext_2[5:2] == 4'd1) ?
                                  (dmem[addr_ext_2[5:2]] ^ 32'h1) : dmem[addr_ext_2[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    logic [64:0] obs;
    logic [64:0] exp;
    if (wen_ext || wen_ext_2) begin
      obs = wen_ext ? {1'b0, addr_ext, wdata_ext} : {1'b1, addr_ext_2, wdata_ext_2};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 64'hDEAD_DEAD_DEAD_DEAD};
      wcount++;
      tests++;
      assert (obs === exp) else begin
        fails++;
        $error("FAIL write observed=%h expected=%h", obs, exp);
      end
    end
    if (wen_ext || ren_ext)     chk("wen_ren_excl_1", 32'(wen_ext && ren_ext), 32'd0);
    if (wen_ext_2 || ren_ext_2) chk("wen_ren_excl_2", 32'(wen_ext_2 && ren_ext_2), 32'd0);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({port, a, d});
  endtask

  task automatic do_start(input logic [9:0] ic, input logic [10:0] dc);
    imem_count = ic;
    dmem_count = dc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({cpu_enable, busy, done, error, s_ready,
                              wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 32'd0);
    chk({tag, "_addr"}, addr_ext | addr_ext_2 | wdata_ext | wdata_ext_2, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  logic [31:0] words [5];

  initial begin
    words[0] = 32'h2008_0005; words[1] = 32'h2109_0001; words[2] = 32'h0;
    words[3] = 32'hA;         words[4] = 32'hB;
    arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    imem_count = '0; dmem_count = '0;
    repeat (3) step();
    chk_all_zero("reset");
    arst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Nominal 3+2 load
    push(0, 0, words[0]); push(0, 4, words[1]); push(0, 8, words[2]);
    push(1, 0, words[3]); push(1, 4, words[4]);
    do_start(10'd3, 11'd2);
    chk("t1_ready", 32'({s_ready, busy}), 32'h3);
    chk("t1_state", 32'(dbg_state), 32'(ST_LOAD_I));
    for (int i = 0; i < 5; i++) send(1'b1, words[i]);
    s_valid = 1'b0;
    chk("t1_vi_state", 32'(dbg_state), 32'(ST_VERIFY_I));
    chk("t1_vi_ren", 32'({ren_ext, s_ready}), 32'h2);
    chk("t1_vi_addr", addr_ext, 32'd0);
    repeat (6) step();
    chk("t1_pre_run", 32'({busy, cpu_enable}), 32'h2);
    step();
    chk("t1_run", 32'({cpu_enable, done, error, busy}), 32'hC);
    chk("t1_writes", 32'(wcount), 32'd5);

    // Restart from RUN with a corrupted data readback
    corrupt_d1 = 1'b1;
    push(0, 0, words[0]); push(0, 4, words[1]); push(0, 8, words[2]);
    push(1, 0, words[3]); push(1, 4, words[4]);
    do_start(10'd3, 11'd2);
    chk("t2_cpu_drop", 32'({cpu_enable, busy}), 32'h1);
    chk("t2_state", 32'(dbg_state), 32'(ST_LOAD_I));
    for (int i = 0; i < 5; i++) send(1'b1, words[i]);
    s_valid = 1'b0;
    repeat (6) step();
    chk("t2_pre_fail", 32'({busy, error}), 32'h2);
    step();
    chk("t2_fail", 32'({error, cpu_enable, done, busy}), 32'h8);
    chk("t2_state_fail", 32'(dbg_state), 32'(ST_FAIL));
    corrupt_d1 = 1'b0;

    // Oversized instruction count
    do_start(10'd513, 11'd2);
    chk("t3_fail", 32'({error, busy, s_ready}), 32'h4);
    chk("t3_state", 32'(dbg_state), 32'(ST_FAIL));
    step();
    chk("t3_no_write", 32'(wcount), 32'd10);

    // Stalled stream, and start ignored during VERIFY_I
    push(0, 0, 32'h111); push(0, 4, 32'h222);
    do_start(10'd2, 11'd0);
    send(1'b1, 32'h111);
    chk("t4_addr_adv", addr_ext, 32'd4);
    send(1'b0, 32'hBAD0);
    chk("t4_gap1", 32'({addr_ext[7:0], 7'd0, wen_ext}), 32'h400);
    send(1'b0, 32'hBAD1);
    chk("t4_gap2", 32'({addr_ext[7:0], 7'd0, wen_ext}), 32'h400);
    chk("t4_gap_state", 32'(dbg_state), 32'(ST_LOAD_I));
    send(1'b1, 32'h222);
    s_valid = 1'b0;
    chk("t4_writes", 32'(wcount), 32'd12);
    chk("t4_vi", 32'(dbg_state), 32'(ST_VERIFY_I));
    do_start(10'd5, 11'd5);
    chk("t4_start_ign", 32'(dbg_state), 32'(ST_VERIFY_I));
    chk("t4_vi_addr", addr_ext, 32'd4);
    step();
    step();
    chk("t4_run", 32'({cpu_enable, error}), 32'h2);

    // Both counts zero
    do_start(10'd0, 11'd0);
    chk("t5_vi", 32'({cpu_enable, ren_ext, ren_ext_2}), 32'd0);
    chk("t5_state", 32'(dbg_state), 32'(ST_VERIFY_I));
    step();
    chk("t5_run", 32'(cpu_enable), 32'd1);

    // Reset during LOAD_D
    push(0, 0, 32'h33); push(1, 0, 32'h44);
    do_start(10'd1, 11'd3);
    send(1'b1, 32'h33);
    send(1'b1, 32'h44);
    chk("t6_ld", 32'(dbg_state), 32'(ST_LOAD_D));
    chk("t6_ld_addr", addr_ext_2, 32'd4);
    s_valid = 1'b0;
    arst_n = 1'b0;
    step();
    chk_all_zero("t6_rst");
    arst_n = 1'b1;
    step();
    chk_all_zero("t6_after");
    chk("t6_writes", 32'(wcount), 32'd14);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_loader.md
EXT_LOADER -- requirements
Module: ext_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 512, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, data-memory capacity in 32-bit words.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port arst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse; latches counts and begins a load.
REQ-006 SHALL have port imem_count  in  10  words to load into instruction memory.
REQ-007 SHALL have port dmem_count  in  11  words to load into data memory.
REQ-008 SHALL have ports s_valid  in  1, s_ready  out  1, s_data  in  32: host word stream, instruction words first, then data words.
REQ-009 SHALL have ports addr_ext  out  32, wen_ext  out  1, ren_ext  out  1, wdata_ext  out  32, rdata_ext  in  32: instruction-memory external port.
REQ-010 SHALL have ports addr_ext_2  out  32, wen_ext_2  out  1, ren_ext_2  out  1, wdata_ext_2  out  32, rdata_ext_2  in  32: data-memory external port.
REQ-011 SHALL have ports cpu_enable  out  1, busy  out  1, done  out  1, error  out  1.

Function
REQ-012 SHALL implement the states IDLE, LOAD_I, LOAD_D, VERIFY_I, VERIFY_D, RUN and FAIL.
REQ-013 SHALL, in IDLE, RUN or FAIL, on start, latch both counts, clear the word counter and both checksums, and go to FAIL if imem_count>IMEM_WORDS or dmem_count>DMEM_WORDS; otherwise go to LOAD_I, skipping to LOAD_D when imem_count==0 and to VERIFY_I when both counts are 0.
REQ-014 SHALL ignore start in LOAD_*/VERIFY_* states.
REQ-015 SHALL assert s_ready combinationally only in LOAD_I and LOAD_D.
REQ-016 SHALL, in LOAD_I, drive wen_ext=s_valid, addr_ext=counter*4 (byte address) and wdata_ext=s_data in the same cycle; one word SHALL be accepted per cycle with no bubbles.
REQ-017 SHALL, in LOAD_D, do the same on the *_2 port.
REQ-018 SHALL, on each accepted word, add s_data to a 32-bit wrapping write checksum, separate for instruction and data memory.
REQ-019 SHALL leave LOAD_x on acceptance of the last word (counter==count-1), resetting the counter.
REQ-020 SHALL, in VERIFY_I/VERIFY_D, assert ren_ext/ren_ext_2 with addr=counter*4 for count consecutive cycles.
REQ-021 SHALL add read data, valid exactly 1 cycle after ren, to a 32-bit wrapping read checksum; a state SHALL exit only after its last returned word is summed.
REQ-022 SHALL skip a VERIFY state whose count is 0.
REQ-023 SHALL, after VERIFY_D, go to RUN if both read checksums equal the write checksums, else to FAIL.
REQ-024 SHALL hold wen/ren low on both ports outside their respective LOAD/VERIFY states, and SHALL never assert wen and ren simultaneously.
REQ-025 SHALL drive cpu_enable=1 and done=1 only in RUN, error=1 only in FAIL, and busy=1 in LOAD_*/VERIFY_*.
REQ-026 SHALL, on start in RUN, drop cpu_enable in the next cycle (state register update).
REQ-027 SHALL stall, holding state, counter and outputs, when s_valid=0 in LOAD; there is no timeout.

Reset
REQ-028 SHALL, while arst_n=0 at a clock edge, enter IDLE with counters, checksums and latched counts zeroed.
REQ-029 SHALL hold all outputs at 0 in IDLE, including s_ready and addresses.
REQ-030 SHALL abort a load in progress on reset mid-operation without issuing any further wen/ren.

Structure
REQ-031 SHALL place the state enumeration, the read latency constant RD_LAT=1 and the byte stride constant 4 in shared package loader_pkg.
REQ-032 SHALL use one sub-module, readback_checker, containing the ren-delay pipeline, the read-checksum accumulator and the compare.

Verification
REQ-033 SHALL cover: imem_count=3, dmem_count=2, words 0x20080005, 0x21090001, 0x0, 0xA, 0xB streamed back-to-back -> wen_ext at addresses 0, 4, 8; wen_ext_2 at 0, 4; RUN with cpu_enable=1 after 3+2 verify reads plus latency.
REQ-034 SHALL cover: same load with a model memory corrupting data word 1 on readback -> FAIL, error=1, cpu_enable=0.
REQ-035 SHALL cover: imem_count=513 -> FAIL on the cycle after start; no wen asserted.
REQ-036 SHALL cover: s_valid toggling 1,0,0,1 -> exactly 2 writes, and addr/counter held during the gaps.
REQ-037 SHALL cover: both counts 0 -> RUN within 2 cycles; arst_n=0 asserted during LOAD_D -> IDLE next edge, all outputs 0.
REQ-038 SHALL cover: start pulsed during VERIFY_I -> ignored; start pulsed in RUN -> cpu_enable=0 next cycle and reload proceeds.
